// File: rtl/code_lock_checker.sv
// rtl/code_lock_checker.sv - validates a synchronized 4-digit entry against KEY with retry lockout
module code_lock_checker #(
    parameter logic [15:0] KEY           = 16'h1234,
    parameter int          MAX_TRY       = 3,
    parameter int          STABLE_CYCLES = 4,
    parameter int          OPEN_CYCLES   = 50_000_000,
    parameter int          FAIL_CYCLES   = 25_000_000,
    parameter int          LOCK_CYCLES   = 500_000_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] Code,
    input  logic [2:0]  Code_Bit,
    output logic        Unlock,
    output logic        Error,
    output logic        Alarm,
    output logic        Clear_Req,
    output logic [1:0]  Try_Cnt,
    output logic [2:0]  State
);

    localparam int T_OF = (OPEN_CYCLES > FAIL_CYCLES) ? OPEN_CYCLES : FAIL_CYCLES;
    localparam int T_MX = (T_OF > LOCK_CYCLES) ? T_OF : LOCK_CYCLES;
    localparam int TW   = (T_MX > 1) ? $clog2(T_MX) : 1;
    localparam int SW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] FAIL_LOAD = TW'(FAIL_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
    localparam logic [SW-1:0] STAB_LOAD = SW'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_QUAL  = 3'd1,
        S_CHECK = 3'd2,
        S_OPEN  = 3'd3,
        S_FAIL  = 3'd4,
        S_LOCK  = 3'd5,
        S_WAIT  = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_code_s1, r_code_s2, r_snap;
    logic [2:0]      r_bit_s1, r_bit_s2;
    logic [SW-1:0]   r_stab;
    logic [TW-1:0]   r_timer;
    logic [1:0]      r_try;
    logic            w_full;
    logic            w_match;
    logic [1:0]      w_try_inc;
    logic            w_lock;

    assign w_full    = (r_bit_s2 == 3'd4);
    assign w_match   = (r_snap == KEY);
    assign w_try_inc = (r_try == 2'd3) ? 2'd3 : r_try + 2'd1;
    assign w_lock    = (32'(w_try_inc) >= MAX_TRY);
    assign State     = r_state;
    assign Try_Cnt   = r_try;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_full) w_next = S_QUAL;
            S_QUAL: begin
                if (!w_full)
                    w_next = S_IDLE;
                else if (r_code_s2 == r_snap && r_stab == '0)
                    w_next = S_CHECK;
            end
            S_CHECK: w_next = w_match ? S_OPEN : (w_lock ? S_LOCK : S_FAIL);
            S_OPEN, S_FAIL, S_LOCK: if (r_timer == '0) w_next = S_WAIT;
            S_WAIT:  if (!w_full) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_IDLE;
            r_code_s1 <= 16'hFFFF;
            r_code_s2 <= 16'hFFFF;
            r_bit_s1  <= 3'd0;
            r_bit_s2  <= 3'd0;
            r_snap    <= 16'hFFFF;
            r_stab    <= '0;
            r_timer   <= '0;
            r_try     <= 2'd0;
            Unlock    <= 1'b0;
            Error     <= 1'b0;
            Alarm     <= 1'b0;
            Clear_Req <= 1'b0;
        end else begin
            r_code_s1 <= Code;
            r_code_s2 <= r_code_s1;
            r_bit_s1  <= Code_Bit;
            r_bit_s2  <= r_bit_s1;
            r_state   <= w_next;
            // Outputs decode the next state so they line up with State.
            Unlock    <= (w_next == S_OPEN);
            Error     <= (w_next == S_FAIL);
            Alarm     <= (w_next == S_LOCK);
            Clear_Req <= (w_next == S_WAIT);
            case (r_state)
                S_IDLE: begin
                    if (w_full) begin
                        r_snap <= r_code_s2;
                        r_stab <= STAB_LOAD;
                    end
                end
                S_QUAL: begin
                    if (r_code_s2 != r_snap) begin
                        r_snap <= r_code_s2;
                        r_stab <= STAB_LOAD;
                    end else if (r_stab != '0) begin
                        r_stab <= r_stab - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_match) begin
                        r_try   <= 2'd0;
                        r_timer <= OPEN_LOAD;
                    end else begin
                        r_try   <= w_try_inc;
                        r_timer <= w_lock ? LOCK_LOAD : FAIL_LOAD;
                    end
                end
                S_OPEN, S_FAIL: begin
                    if (r_timer != '0) r_timer <= r_timer - 1'b1;
                end
                S_LOCK: begin
                    if (r_timer != '0) r_timer <= r_timer - 1'b1;
                    else               r_try   <= 2'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_code_lock_checker.sv
// tb/tb_code_lock_checker.sv - directed bench with cycle-level reference model for code_lock_checker
module tb_code_lock_checker;

    localparam logic [15:0] KEY = 16'h1234;
    localparam int MAXT = 3, STAB = 4, OPEN_N = 8, FAIL_N = 6, LOCK_N = 20;
    localparam int ST_IDLE = 0, ST_QUAL = 1, ST_CHECK = 2, ST_OPEN = 3,
                   ST_FAIL = 4, ST_LOCK = 5, ST_WAIT = 6;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] Code;
    logic [2:0]  Code_Bit;
    logic        Unlock, Error, Alarm, Clear_Req;
    logic [1:0]  Try_Cnt;
    logic [2:0]  State;

    int n_tests = 0;
    int n_fail  = 0;

    code_lock_checker #(
        .KEY(KEY), .MAX_TRY(MAXT), .STABLE_CYCLES(STAB),
        .OPEN_CYCLES(OPEN_N), .FAIL_CYCLES(FAIL_N), .LOCK_CYCLES(LOCK_N)
    ) dut (
        .CLK(CLK), .RESET(RESET), .Code(Code), .Code_Bit(Code_Bit),
        .Unlock(Unlock), .Error(Error), .Alarm(Alarm), .Clear_Req(Clear_Req),
        .Try_Cnt(Try_Cnt), .State(State)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the FSM sees is the input from two edges ago;
    // timed phases count remaining cycles, qualification counts cycles of agreement.
    int          m_st, m_left, m_age, m_try;
    logic [15:0] m_snap, h1c, h2c;
    int          h1b, h2b;

    task automatic model_reset();
        m_st = ST_IDLE; m_left = 0; m_age = 0; m_try = 0;
        m_snap = 16'hFFFF; h1c = 16'hFFFF; h2c = 16'hFFFF; h1b = 0; h2b = 0;
    endtask

    task automatic model_step(input logic [15:0] c, input int b);
        logic [15:0] sc;
        bit full;
        sc = h2c;
        full = (h2b == 4);
        h2c = h1c; h2b = h1b; h1c = c; h1b = b;
        case (m_st)
            ST_IDLE: if (full) begin m_st = ST_QUAL; m_snap = sc; m_age = 1; end
            ST_QUAL: begin
                if (!full) m_st = ST_IDLE;
                else if (sc != m_snap) begin m_snap = sc; m_age = 1; end
                else if (m_age >= STAB) m_st = ST_CHECK;
                else m_age++;
            end
            ST_CHECK: begin
                if (m_snap == KEY) begin
                    m_try = 0; m_st = ST_OPEN; m_left = OPEN_N;
                end else begin
                    m_try = (m_try + 1 > 3) ? 3 : m_try + 1;
                    if (m_try >= MAXT) begin m_st = ST_LOCK; m_left = LOCK_N; end
                    else begin m_st = ST_FAIL; m_left = FAIL_N; end
                end
            end
            ST_OPEN, ST_FAIL, ST_LOCK: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_st == ST_LOCK) m_try = 0;
                    m_st = ST_WAIT;
                end
            end
            ST_WAIT: if (!full) m_st = ST_IDLE;
            default: m_st = ST_IDLE;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            #1;
            if (!RESET) model_reset();
            else model_step(Code, int'(Code_Bit));
            chk("m_state",  int'(State),     m_st);
            chk("m_unlock", int'(Unlock),    int'(m_st == ST_OPEN));
            chk("m_error",  int'(Error),     int'(m_st == ST_FAIL));
            chk("m_alarm",  int'(Alarm),     int'(m_st == ST_LOCK));
            chk("m_clrreq", int'(Clear_Req), int'(m_st == ST_WAIT));
            chk("m_try",    int'(Try_Cnt),   m_try);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_state(input string name, input int st, input int budget, output int n);
        n = 0;
        while (int'(State) != st && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(name, int'(State), st);
    endtask

    task automatic clear_entry(input string name);
        Code_Bit = 3'd0;
        Code = 16'hFFFF;
        cyc(3);
        chk(name, int'(State), ST_IDLE);
    endtask

    task automatic run_entry(input string name, input logic [15:0] c, input int st,
                             input int len_exp, input int try_in, input int try_after,
                             input bit mid_key);
        int n, len;
        Code = c;
        Code_Bit = 3'd4;
        wait_state({name, "_enter"}, st, 40, n);
        chk({name, "_try"}, int'(Try_Cnt), try_in);
        len = 0;
        while (int'(State) == st && len < 200) begin
            if (mid_key && len == 5) Code = KEY;
            chk({name, "_nounlock"}, int'(Unlock), int'(st == ST_OPEN));
            @(negedge CLK);
            len++;
        end
        chk({name, "_len"}, len, len_exp);
        chk({name, "_wait"}, int'(State), ST_WAIT);
        chk({name, "_clrreq"}, int'(Clear_Req), 1);
        chk({name, "_try_after"}, int'(Try_Cnt), try_after);
        cyc(3);
        chk({name, "_wait_hold"}, int'(State), ST_WAIT);
        clear_entry({name, "_idle"});
    endtask

    initial begin
        int n;
        RESET = 1'b1;
        Code = KEY;
        Code_Bit = 3'd4;
        #1 RESET = 1'b0;

        // 1: reset with a valid entry already applied
        cyc(3);
        chk("rst_state", int'(State), 0);
        chk("rst_outs", int'({Unlock, Error, Alarm, Clear_Req}), 0);
        chk("rst_try", int'(Try_Cnt), 0);
        RESET = 1'b1;
        wait_state("t1_check", ST_CHECK, 20, n);
        chk("t1_check_latency", n, 7);
        cyc(1);
        n = 0;
        while (Unlock && n < 50) begin @(negedge CLK); n++; end
        chk("t1_unlock_len", n, OPEN_N);
        chk("t1_clrreq", int'(Clear_Req), 1);
        cyc(4);
        chk("t1_clrreq_hold", int'(Clear_Req), 1);
        clear_entry("t1_idle");

        // 2: wrong code, then correct code
        run_entry("t2_wrong", 16'h1235, ST_FAIL, FAIL_N, 1, 1, 1'b0);
        run_entry("t2_right", KEY, ST_OPEN, OPEN_N, 0, 0, 1'b0);

        // 3: three mismatches lead to lockout; key during lockout is ignored
        run_entry("t3_w1", 16'h0000, ST_FAIL, FAIL_N, 1, 1, 1'b0);
        run_entry("t3_w2", 16'hFFFF, ST_FAIL, FAIL_N, 2, 2, 1'b0);
        run_entry("t3_lock", 16'h4321, ST_LOCK, LOCK_N, 3, 0, 1'b1);

        // 4: unstable entry never qualifies
        Code_Bit = 3'd4;
        for (int k = 0; k < 12; k++) begin
            Code = (k % 2 == 1) ? 16'h1334 : 16'h1234;
            for (int j = 0; j < 2; j++) begin
                @(negedge CLK);
                if (k >= 2) chk("t4_qual", int'(State), ST_QUAL);
            end
        end
        Code = KEY;
        wait_state("t4_check", ST_CHECK, 20, n);
        chk("t4_check_latency", n, 7);
        wait_state("t4_wait", ST_WAIT, 40, n);
        clear_entry("t4_idle");

        // 5: partial and illegal digit counts
        Code = 16'hF234;
        Code_Bit = 3'd3;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            chk("t5_partial", int'(State), ST_IDLE);
        end
        Code = KEY;
        Code_Bit = 3'd7;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            chk("t5_illegal", int'(State), ST_IDLE);
        end
        clear_entry("t5_idle");

        // 6: reset during OPEN and during FAIL
        Code = KEY;
        Code_Bit = 3'd4;
        wait_state("t6_open", ST_OPEN, 40, n);
        cyc(2);
        chk("t6_unlock_pre", int'(Unlock), 1);
        RESET = 1'b0;
        #1;
        chk("t6_unlock_async", int'(Unlock), 0);
        chk("t6_state_async", int'(State), 0);
        cyc(2);
        Code = 16'hFFFF;
        Code_Bit = 3'd0;
        RESET = 1'b1;
        cyc(3);
        chk("t6_state_after", int'(State), 0);
        chk("t6_try_after", int'(Try_Cnt), 0);

        Code = 16'h0000;
        Code_Bit = 3'd4;
        wait_state("t6_fail", ST_FAIL, 40, n);
        chk("t6_fail_try", int'(Try_Cnt), 1);
        cyc(1);
        RESET = 1'b0;
        #1;
        chk("t6_error_async", int'(Error), 0);
        chk("t6_try_async", int'(Try_Cnt), 0);
        cyc(2);
        Code = 16'hFFFF;
        Code_Bit = 3'd0;
        RESET = 1'b1;
        cyc(3);
        chk("t6_state_end", int'(State), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
